fib_seq_gen: RTL and testbench
==============================

// Module: fib_seq_gen
// PURPOSE
//  Parametrised Fibonacci-type sequence generator with programmable seeds and term count.
//  Recurrence: t[k+2] = t[k+1] + t[k]; seeds (0,1) give Fibonacci, (2,1) give Lucas.
//  Streams terms over a valid/ready interface with backpressure and detects width overflow.
//  Successor to the free-running fibonacci block; sits between control logic and a stream consumer.
// PARAMETERS
//  DATA_WIDTH  32  width of seeds and output terms
//  CNT_WIDTH   8   width of num_terms and the internal term counter
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  rst         in   1           synchronous, active-high reset
//  start       in   1           begin a sequence; sampled only in IDLE
//  seed0       in   DATA_WIDTH  term t[0]; latched on accepted start
//  seed1       in   DATA_WIDTH  term t[1]; latched on accepted start
//  num_terms   in   CNT_WIDTH   terms to emit; latched on accepted start
//  busy        out  1           high while in RUN
//  dout_valid  out  1           dout holds a valid term
//  dout_ready  in   1           consumer accepts dout this cycle
//  dout        out  DATA_WIDTH  current term
//  last        out  1           qualifies dout as the final requested term
//  overflow    out  1           sticky; sequence stopped because the next term exceeded DATA_WIDTH
//  done        out  1           one-cycle pulse when a sequence ends
// BEHAVIOUR
//  - Reset: state IDLE; busy, dout_valid, dout, last, overflow and done all 0; internal a/b/count 0.
//  - Reset mid-run: abort immediately, no done pulse, no pending terms kept.
//  - States: IDLE, RUN. All outputs are registered.
//  - IDLE + start + num_terms!=0: a<=seed0, b<=seed1, rem<=num_terms, overflow<=0, go RUN.
//    dout_valid=1 with dout=seed0 in the cycle after start (latency 1).
//  - IDLE + start + num_terms==0: overflow<=0, done=1 next cycle, stay IDLE, no term emitted.
//  - start while in RUN is ignored.
//  - RUN: dout=a, dout_valid=1, last=(rem==1).
//    dout, last and dout_valid stay stable while dout_valid & !dout_ready.
//  - Handshake (dout_valid & dout_ready):
//    a<=b; b<=a+b, computed DATA_WIDTH+1 wide; rem<=rem-1.
//    Per-slot overflow flags: a_ovf<=b_ovf; b_ovf<=carry|a_ovf|b_ovf.
//  - End on last: handshake with rem==1 -> IDLE; dout_valid=0 and done=1 in the next cycle.
//  - End on overflow: handshake with rem>1 and b_ovf==1 (next term unrepresentable)
//    -> IDLE; overflow<=1, done=1, dout_valid=0 next cycle.
//    last is never asserted for an overflow-truncated sequence.
//  - Seeds are never flagged as overflow; an overflowed value is never presented on dout.
//  - overflow holds until the next accepted start or rst.
//  - done is a single-cycle pulse; start may be accepted in the same cycle done is high (state is IDLE).
// CONFIGURATION
//  FIB_SEQ_INDEX_EN defined: adds output dout_index [CNT_WIDTH]:
//    zero-based index of the term on dout; 0 on start; +1 per handshake; reset value 0.
//  FIB_SEQ_INDEX_EN undefined: port dout_index and its counter are absent; all other behaviour identical.
// TESTING
//  1. seeds 0,1, num_terms=10, ready=1 -> 0,1,1,2,3,5,8,13,21,34; last only on 34; done one cycle later.
//  2. seeds 2,1, num_terms=5, ready toggling 1/0 -> 2,1,3,4,7; dout held stable on every ready=0 cycle.
//  3. DATA_WIDTH=8, seeds 0,1, num_terms=20 -> 14 terms 0..233, then overflow=1 and done;
//     last never high; dout_index reaches 13.
//  4. num_terms=0 -> done one cycle after start; dout_valid and busy stay 0.
//  5. num_terms=1, seeds 7,9 -> single term 7 with last=1; done next cycle.
//  6. start pulsed in RUN -> ignored; rst after 3 terms -> dout_valid=0 next cycle, no done;
//     new start then streams normally from seed0.

Source files
------------

// File: rtl/fib_seq_gen.sv
// Fibonacci-type sequence generator: programmable seeds and term count, valid/ready term stream.
// Latency: first term (seed0) on dout one cycle after an accepted start; one term per handshake after that.
// Backpressure: dout/last/dout_valid hold while dout_ready is low; generation stalls until the handshake.
// Optional feature macro: FIB_SEQ_INDEX_EN adds the dout_index output and its counter.
module fib_seq_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed0,
    input  logic [DATA_WIDTH-1:0] seed1,
    input  logic [CNT_WIDTH-1:0]  num_terms,
    output logic                  busy,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  last,
    output logic                  overflow,
    output logic                  done
`ifdef FIB_SEQ_INDEX_EN
    ,
    output logic [CNT_WIDTH-1:0]  dout_index
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);

    state_t                 state, state_n;
    // a is the term on dout, b the one after it; the _ovf flags mark slots whose true value did not fit.
    logic [DATA_WIDTH-1:0]  a, a_n;
    logic [DATA_WIDTH-1:0]  b, b_n;
    logic                   a_ovf, a_ovf_n;
    logic                   b_ovf, b_ovf_n;
    logic [CNT_WIDTH-1:0]   rem, rem_n;
    logic                   busy_n, dout_valid_n, last_n, overflow_n, done_n;
    logic [DATA_WIDTH:0]    sum;
    logic                   hs;
`ifdef FIB_SEQ_INDEX_EN
    logic [CNT_WIDTH-1:0]   idx, idx_n;
`endif

    // Next term is computed one bit wider so the carry marks an unrepresentable value.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign hs   = dout_valid & dout_ready;
    assign dout = a;
`ifdef FIB_SEQ_INDEX_EN
    assign dout_index = idx;
`endif

    // State and output registers; reset aborts any sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            a_ovf      <= 1'b0;
            b_ovf      <= 1'b0;
            rem        <= '0;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            last       <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
`ifdef FIB_SEQ_INDEX_EN
            idx        <= '0;
`endif
        end else begin
            state      <= state_n;
            a          <= a_n;
            b          <= b_n;
            a_ovf      <= a_ovf_n;
            b_ovf      <= b_ovf_n;
            rem        <= rem_n;
            busy       <= busy_n;
            dout_valid <= dout_valid_n;
            last       <= last_n;
            overflow   <= overflow_n;
            done       <= done_n;
`ifdef FIB_SEQ_INDEX_EN
            idx        <= idx_n;
`endif
        end
    end

    // Next-state and next-output logic: load on start, advance on handshake, stop on last or overflow.
    always_comb begin
        state_n      = state;
        a_n          = a;
        b_n          = b;
        a_ovf_n      = a_ovf;
        b_ovf_n      = b_ovf;
        rem_n        = rem;
        busy_n       = busy;
        dout_valid_n = dout_valid;
        last_n       = last;
        overflow_n   = overflow;
        done_n       = 1'b0;
`ifdef FIB_SEQ_INDEX_EN
        idx_n        = idx;
`endif
        unique case (state)
            IDLE: begin
                busy_n       = 1'b0;
                dout_valid_n = 1'b0;
                last_n       = 1'b0;
                if (start) begin
                    overflow_n = 1'b0;
                    if (num_terms != CNT_ZERO) begin
                        state_n      = RUN;
                        a_n          = seed0;
                        b_n          = seed1;
                        a_ovf_n      = 1'b0;
                        b_ovf_n      = 1'b0;
                        rem_n        = num_terms;
                        busy_n       = 1'b1;
                        dout_valid_n = 1'b1;
                        last_n       = (num_terms == CNT_ONE);
`ifdef FIB_SEQ_INDEX_EN
                        idx_n        = '0;
`endif
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    if (rem == CNT_ONE || b_ovf) begin
                        // Final requested term taken, or the following term cannot be represented.
                        state_n      = IDLE;
                        busy_n       = 1'b0;
                        dout_valid_n = 1'b0;
                        last_n       = 1'b0;
                        done_n       = 1'b1;
                        overflow_n   = (rem != CNT_ONE);
                    end else begin
                        a_n     = b;
                        b_n     = sum[DATA_WIDTH-1:0];
                        a_ovf_n = b_ovf;
                        b_ovf_n = sum[DATA_WIDTH] | a_ovf | b_ovf;
                        rem_n   = rem - CNT_ONE;
                        last_n  = (rem == CNT_TWO);
`ifdef FIB_SEQ_INDEX_EN
                        idx_n   = idx + CNT_ONE;
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Randomized bench for fib_seq_gen (8-bit data so overflow is reachable) against an exact-arithmetic model.
// Terms are checked on every handshake; held outputs are checked on every stalled cycle.
// Directed scenarios first, then random seeds, lengths and ready patterns.
module tb_fib_seq_gen;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed0, seed1;
    logic [CW-1:0] num_terms;
    logic          busy, dout_valid, dout_ready, last, overflow, done;
    logic [DW-1:0] dout;
`ifdef FIB_SEQ_INDEX_EN
    logic [CW-1:0] dout_index;
`endif

    int checks = 0;
    int errors = 0;
    longint exp_q[$];

    always #5 clk = ~clk;

    fib_seq_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed0      (seed0),
        .seed1      (seed1),
        .num_terms  (num_terms),
        .busy       (busy),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .last       (last),
        .overflow   (overflow),
        .done       (done)
`ifdef FIB_SEQ_INDEX_EN
        ,
        .dout_index (dout_index)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact terms t[k]=t[k-1]+t[k-2], truncated at the first one that needs more than DW bits.
    task automatic build_exp(input longint s0, input longint s1, input int n, output bit ovf);
        longint t;
        exp_q.delete();
        ovf = 1'b0;
        if (n >= 1) exp_q.push_back(s0);
        if (n >= 2) exp_q.push_back(s1);
        for (int k = 2; k < n; k++) begin
            t = exp_q[k-1] + exp_q[k-2];
            if (t >= (longint'(1) << DW)) begin
                ovf = 1'b1;
                break;
            end
            exp_q.push_back(t);
        end
    endtask

    // mode: 0 ready always high, 1 ready toggles 1/0, 2 random ready.
    // inject: pulse start with other seeds while running; rst_after: reset after that many terms (0 = never).
    task automatic run_seq(input int s0, input int s1, input int n, input int mode,
                           input bit inject, input int rst_after);
        bit     ovf;
        int     idx;
        int     cyc;
        bit     stalled;
        logic [DW-1:0] held_dout;
        logic   held_last;
        bit     tog;
        build_exp(longint'(s0), longint'(s1), n, ovf);
        @(negedge clk);
        start      = 1'b1;
        seed0      = DW'(s0);
        seed1      = DW'(s1);
        num_terms  = CW'(n);
        dout_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            check("zero_done", done, 1);
            check("zero_valid", dout_valid, 0);
            check("zero_busy", busy, 0);
            check("zero_ovf_clr", overflow, 0);
            @(negedge clk);
            check("zero_done_pulse", done, 0);
            check("zero_valid2", dout_valid, 0);
            return;
        end
        idx = 0; cyc = 0; stalled = 1'b0; tog = 1'b1;
        held_dout = '0; held_last = 1'b0;
        while (!done && cyc < 2000) begin
            check("valid", dout_valid, 1);
            check("busy", busy, 1);
            if (stalled) begin
                check("hold_dout", dout, held_dout);
                check("hold_last", last, held_last);
            end
            start = (inject && cyc == 2);
            seed0 = inject ? DW'(99) : DW'(s0);
            case (mode)
                0: dout_ready = 1'b1;
                1: begin dout_ready = tog; tog = ~tog; end
                default: dout_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (dout_valid && dout_ready) begin
                if (idx < exp_q.size()) check("term", dout, exp_q[idx]);
                else check("extra_term", idx, exp_q.size());
                check("last", last, (idx == n - 1));
`ifdef FIB_SEQ_INDEX_EN
                check("index", dout_index, idx);
`endif
                idx++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_dout = dout;
                held_last = last;
            end
            @(negedge clk);
            cyc++;
            if (rst_after != 0 && idx == rst_after) begin
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_valid", dout_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                @(negedge clk);
                check("rst_no_done", done, 0);
                return;
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("term_count", idx, exp_q.size());
        check("overflow", overflow, ovf);
        check("end_valid", dout_valid, 0);
        check("end_busy", busy, 0);
        check("end_last", last, 0);
        dout_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ovf_sticky", overflow, ovf);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; num_terms = '0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy0", busy, 0);
        check("rst_valid0", dout_valid, 0);
        check("rst_dout0", dout, 0);
        check("rst_last0", last, 0);
        check("rst_ovf0", overflow, 0);
        check("rst_done0", done, 0);
`ifdef FIB_SEQ_INDEX_EN
        check("rst_index0", dout_index, 0);
`endif
        rst = 1'b0;
        run_seq(0, 1, 10, 0, 1'b0, 0);    // Fibonacci, ready high
        run_seq(2, 1, 5, 1, 1'b0, 0);     // Lucas, ready toggling
        run_seq(0, 1, 20, 2, 1'b0, 0);    // overflow after 14 terms
        run_seq(0, 1, 0, 0, 1'b0, 0);     // zero terms; also clears overflow
        run_seq(7, 9, 1, 0, 1'b0, 0);     // single term
        run_seq(0, 1, 10, 0, 1'b1, 3);    // start ignored in RUN, reset after 3 terms
        run_seq(3, 4, 6, 0, 1'b0, 0);     // normal restart after reset
        run_seq(200, 100, 5, 2, 1'b0, 0); // overflow on the first computed term
        for (int i = 0; i < 40; i++) begin
            int a0, a1;
            a0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            a1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            run_seq(a0, a1, int'($urandom_range(0, 20)), int'($urandom_range(0, 2)), 1'b0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
